pack_fifo: RTL and testbench
============================

// Module: pack_fifo
// PURPOSE
//  Parametrised sync FIFO for the video_in path: buffers pixel words from capture and tells the
//  bus-master side when a full burst packet (NB_PACK words) can be fetched. Successor of the fixed
//  32x64 FIFO: adds configurable width/depth/threshold, occupancy output, almost_full, read-valid,
//  underflow protection, synchronous flush and write-through on full.
// PARAMETERS
//  DATA_SIZE  32  word width in bits
//  ADDR_SIZE  6   log2(depth); depth D = 2**ADDR_SIZE
//  NB_PACK    16  words per packet; nb_pack_available threshold, 1..D
//  AF_MARGIN  4   almost_full asserts when level >= D-AF_MARGIN
// PORTS
//  clk                in   1            single clock, rising edge
//  nRST               in   1            asynchronous active-low reset
//  clear              in   1            synchronous flush, priority over w_e/r_ack
//  data_in            in   DATA_SIZE    write data
//  w_e                in   1            write request
//  r_ack              in   1            read request (pop head)
//  data_out           out  DATA_SIZE    read data
//  data_valid         out  1            data_out carries popped word this cycle
//  level              out  ADDR_SIZE+1  current occupancy, 0..D
//  nb_pack_available  out  1            level >= NB_PACK
//  almost_full        out  1            level >= D-AF_MARGIN
//  full               out  1            level == D
//  empty              out  1            level == 0
//  overflow           out  1            sticky: write dropped (macro-gated)
//  underflow          out  1            sticky: read on empty ignored (macro-gated)
// BEHAVIOUR
//  - Reset (nRST low, async): rd/wr pointers 0, level 0, data_out 0, data_valid 0, sticky flags 0.
//    Mid-operation reset discards contents; flags take reset values in the same cycle.
//  - wr_ok = w_e & (~full | rd_ok); rd_ok = r_ack & ~empty. Accepted write stores at wr_ptr, wr_ptr+1.
//  - Accepted read: RAM read at rd_ptr, rd_ptr+1; data_out/data_valid registered,
//    latency 1 cycle after the r_ack edge. data_valid high exactly one cycle per accepted read;
//    data_out holds its value otherwise.
//  - level: +1 on wr_ok only, -1 on rd_ok only, unchanged on both. Never exceeds D or drops below 0.
//  - Full & w_e & r_ack: both accepted (write-through), level stays D. Full & w_e & ~r_ack: write dropped.
//  - Empty & r_ack: read ignored, no pointer move, data_valid 0. Empty & w_e & r_ack: write only.
//  - Pointers ADDR_SIZE bits, wrap naturally D-1 -> 0. level is the only full/empty source.
//  - Status outputs are combinational from registered level: no extra latency.
//  - clear: pointers and level to 0 next edge, data_valid 0, w_e/r_ack ignored that cycle.
//    Sticky flags also cleared. RAM contents not erased.
// CONFIGURATION
//  PACK_FIFO_ERR_FLAGS_EN defined: overflow sets on any dropped write (w_e & ~wr_ok),
//    underflow on any ignored read (r_ack & empty). Both hold until nRST or clear.
//  Not defined: overflow/underflow ports present, tied to 0, no flag registers.
// STRUCTURE
//  - Package pack_fifo_pkg: default DATA_SIZE/ADDR_SIZE/NB_PACK/AF_MARGIN, typedefs
//    word_t (logic [DATA_SIZE-1:0]), ptr_t ([ADDR_SIZE-1:0]), lvl_t ([ADDR_SIZE:0]).
//  - Sub-module fifo_dpram: simple dual-port RAM, port A sync write, port B sync read, 1 clk.
//    Pointer/level/flag logic in pack_fifo.
// TESTING (defaults D=64, NB_PACK=16, AF_MARGIN=4)
//  1 Reset: 16 writes then nRST low mid-burst -> level=0, empty=1, data_valid=0 immediately.
//  2 Fill/drain: write 0..63 -> full=1 at level 64, almost_full from level 60, nb_pack_available
//    from 16. 64 reads -> data_out 0..63 in order, each 1 cycle after r_ack, empty=1 at end.
//  3 Full: write 65 with no read -> dropped, level 64, overflow=1 (macro on) / 0 (off).
//    Then w_e+r_ack -> level 64, pops 0, 65 stored as last word.
//  4 Empty: r_ack on empty -> data_valid 0, pointers unchanged, underflow=1 if macro on.
//    w_e+r_ack on empty -> level 1.
//  5 Wrap: 200 words streamed with random w_e/r_ack, level kept 1..63 -> order preserved
//    across pointer wrap, level matches scoreboard every cycle.
//  6 clear: with level 40 and w_e=1 -> next cycle level=0, empty=1, written word not stored,
//    sticky flags 0.

Source files
------------

// File: rtl/pack_fifo_pkg.sv
// Shared defaults and word/pointer/level types for the pack_fifo block.
// Build option: PACK_FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow registers.
package pack_fifo_pkg;
  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 6;
  localparam int DEF_NB_PACK   = 16;
  localparam int DEF_AF_MARGIN = 4;

  typedef logic [DEF_DATA_SIZE-1:0] word_t;
  typedef logic [DEF_ADDR_SIZE-1:0] ptr_t;
  typedef logic [DEF_ADDR_SIZE:0]   lvl_t;
endpackage

// File: rtl/pack_fifo_if.sv
// Handshake/status bundle between the capture/bus side and pack_fifo.
//   master : drives clear, data_in, w_e, r_ack; observes data and status
//   slave  : the FIFO itself
interface pack_fifo_if
  import pack_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
  logic                 clear;
  logic [DATA_SIZE-1:0] data_in;
  logic                 w_e;
  logic                 r_ack;
  logic [DATA_SIZE-1:0] data_out;
  logic                 data_valid;
  logic [ADDR_SIZE:0]   level;
  logic                 nb_pack_available;
  logic                 almost_full;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output clear, data_in, w_e, r_ack,
    input  data_out, data_valid, level, nb_pack_available,
           almost_full, full, empty, overflow, underflow
  );

  modport slave (
    input  clear, data_in, w_e, r_ack,
    output data_out, data_valid, level, nb_pack_available,
           almost_full, full, empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: port A synchronous write, port B synchronous read (1 clk).
// The read register only loads on i_re, so o_rdata holds between reads.
// Ports: clk, rst_n (async low, clears read register only), i_we/i_waddr/i_wdata,
//        i_re/i_raddr, o_rdata.
module fifo_dpram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-before-write: a same-address write-through returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/pack_fifo.sv
// Parametrised sync FIFO for the video_in path with burst-packet availability.
// Ports: clk, nRST (async low), bus (pack_fifo_if.slave: clear, data_in, w_e, r_ack,
//        data_out, data_valid, level, nb_pack_available, almost_full, full, empty,
//        overflow, underflow).
// Build option: PACK_FIFO_ERR_FLAGS_EN -> sticky overflow/underflow registers;
//               otherwise those outputs are tied low.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int NB_PACK   = DEF_NB_PACK,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic        clk,
  input  logic        nRST,
  pack_fifo_if.slave  bus
);
  localparam int D = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] LVL_FULL = (ADDR_SIZE+1)'(D);
  localparam logic [ADDR_SIZE:0] LVL_AF   = (ADDR_SIZE+1)'(D - AF_MARGIN);
  localparam logic [ADDR_SIZE:0] LVL_PACK = (ADDR_SIZE+1)'(NB_PACK);

  logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_SIZE:0]   r_level;
  logic                 r_data_valid;

  logic w_full, w_empty, w_rd_ok, w_wr_ok, w_rd_en, w_wr_en;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  // A read frees the slot the concurrent write lands in, so full still accepts it.
  assign w_rd_ok = bus.r_ack & ~w_empty;
  assign w_wr_ok = bus.w_e & (~w_full | w_rd_ok);
  assign w_rd_en = w_rd_ok & ~bus.clear;
  assign w_wr_en = w_wr_ok & ~bus.clear;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_data_valid <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_data_valid <= w_rd_ok;
    end
  end

  fifo_dpram #(
    .DW (DATA_SIZE),
    .AW (ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (nRST),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.data_out)
  );

  assign bus.data_valid        = r_data_valid;
  assign bus.level             = r_level;
  assign bus.full              = w_full;
  assign bus.empty             = w_empty;
  assign bus.almost_full       = (r_level >= LVL_AF);
  assign bus.nb_pack_available = (r_level >= LVL_PACK);

`ifdef PACK_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.w_e & ~w_wr_ok)   r_overflow  <= 1'b1;
      if (bus.r_ack & w_empty)  r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_pack_fifo.sv
// Self-checking bench for pack_fifo (D=64, NB_PACK=16, AF_MARGIN=4).
module tb_pack_fifo;
  import pack_fifo_pkg::*;

  localparam int D  = 64;
  localparam int AF = 4;
  localparam int NP = 16;
`ifdef PACK_FIFO_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk;
  logic nRST;

  pack_fifo_if #(.DATA_SIZE(32), .ADDR_SIZE(6)) bus();

  pack_fifo #(
    .DATA_SIZE (32),
    .ADDR_SIZE (6),
    .NB_PACK   (NP),
    .AF_MARGIN (AF)
  ) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of stored words plus last popped word/valid and sticky flags.
  word_t m_q[$];
  word_t m_dout;
  bit    m_dv, m_ovf, m_udf;

  typedef struct {
    bit    we, ra, clr;
    word_t din;
    lvl_t  exp_level;
    bit    exp_dv;
    word_t exp_dout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  function automatic void model_step(input bit we, ra, clr, input word_t din);
    int  n;
    bit  rd, wr;
    n = m_q.size();
    if (clr) begin
      m_q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd = ra && (n != 0);
      wr = we && ((n != D) || rd);
      if (we && !wr)     m_ovf = 1'b1;
      if (ra && (n == 0)) m_udf = 1'b1;
      if (rd) m_dout = m_q.pop_front();
      m_dv = rd;
      if (wr) m_q.push_back(din);
    end
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".level"},       bus.level, n);
    chk({tag, ".empty"},       bus.empty, n == 0);
    chk({tag, ".full"},        bus.full, n == D);
    chk({tag, ".almost_full"}, bus.almost_full, n >= D - AF);
    chk({tag, ".nb_pack"},     bus.nb_pack_available, n >= NP);
    chk({tag, ".data_valid"},  bus.data_valid, m_dv);
    chk({tag, ".data_out"},    bus.data_out, m_dout);
    chk({tag, ".overflow"},    bus.overflow, FLAGS_ON & m_ovf);
    chk({tag, ".underflow"},   bus.underflow, FLAGS_ON & m_udf);
  endtask

  task automatic step(input string tag, input bit we, ra, clr, input word_t din);
    bus.w_e     = we;
    bus.r_ack   = ra;
    bus.clear   = clr;
    bus.data_in = din;
    @(posedge clk);
    model_step(we, ra, clr, din);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.w_e = 1'b0; bus.r_ack = 1'b0; bus.clear = 1'b0; bus.data_in = '0;
    nRST = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    nRST = 1'b1;
  endtask

  vec_t vt[10];

  initial begin
    int pushed, guard;
    bit we, ra, clr;

    // Hand-derived sequence covering empty reads, write-only on empty and clear.
    vt[0] = '{0, 1, 0, 32'h0,  7'd0, 0, 32'h0};
    vt[1] = '{1, 1, 0, 32'hAA, 7'd1, 0, 32'h0};
    vt[2] = '{1, 0, 0, 32'hBB, 7'd2, 0, 32'h0};
    vt[3] = '{0, 1, 0, 32'h0,  7'd1, 1, 32'hAA};
    vt[4] = '{1, 1, 0, 32'hCC, 7'd1, 1, 32'hBB};
    vt[5] = '{0, 0, 0, 32'h0,  7'd1, 0, 32'hBB};
    vt[6] = '{1, 0, 1, 32'hDD, 7'd0, 0, 32'hBB};
    vt[7] = '{0, 1, 0, 32'h0,  7'd0, 0, 32'hBB};
    vt[8] = '{1, 0, 0, 32'hEE, 7'd1, 0, 32'hBB};
    vt[9] = '{0, 1, 0, 32'h0,  7'd0, 1, 32'hEE};

    do_reset();

    foreach (vt[i]) begin
      step("vec", vt[i].we, vt[i].ra, vt[i].clr, vt[i].din);
      chk("vec.level_tbl", bus.level, vt[i].exp_level);
      chk("vec.dv_tbl",    bus.data_valid, vt[i].exp_dv);
      chk("vec.dout_tbl",  bus.data_out, vt[i].exp_dout);
    end

    // Async reset mid-burst: 16 writes, one pop so data_valid is high, then reset.
    for (int i = 0; i < 16; i++) step("burst", 1, 0, 0, word_t'(100 + i));
    step("burst_pop", 0, 1, 0, '0);
    chk("burst.dv_before_rst", bus.data_valid, 1'b1);
    do_reset();

    // Fill 0..63, then overflow attempt, write-through, and full drain.
    for (int i = 0; i < D; i++) step("fill", 1, 0, 0, word_t'(i));
    chk("fill.full", bus.full, 1'b1);
    step("drop65", 1, 0, 0, 32'd65);
    chk("drop65.level", bus.level, 7'd64);
    chk("drop65.ovf", bus.overflow, FLAGS_ON);
    step("wthru", 1, 1, 0, 32'd65);
    chk("wthru.dout", bus.data_out, 32'd0);
    chk("wthru.level", bus.level, 7'd64);
    for (int i = 1; i < D; i++) begin
      step("drain", 0, 1, 0, '0);
      chk("drain.order", bus.data_out, word_t'(i));
    end
    step("drain_last", 0, 1, 0, '0);
    chk("drain.last65", bus.data_out, 32'd65);
    chk("drain.empty", bus.empty, 1'b1);

    // Empty corners.
    step("rd_empty", 0, 1, 0, '0);
    chk("rd_empty.udf", bus.underflow, FLAGS_ON);
    step("wr_rd_empty", 1, 1, 0, 32'h1234);
    chk("wr_rd_empty.level", bus.level, 7'd1);
    step("clr0", 0, 0, 1, '0);

    // Streaming across pointer wrap with level held in 1..63.
    step("prime", 1, 0, 0, $urandom);
    pushed = 1;
    guard  = 0;
    while (pushed < 200 && guard < 5000) begin
      we = $urandom_range(0, 1);
      ra = $urandom_range(0, 1);
      if (m_q.size() <= 1)  ra = 1'b0;
      if (m_q.size() >= 63) we = 1'b0;
      if (we) pushed++;
      step("wrap", we, ra, 0, $urandom);
      guard++;
    end
    chk("wrap.budget", guard < 5000, 1'b1);

    // clear with level 40 and a concurrent write.
    step("clr1", 0, 0, 1, '0);
    for (int i = 0; i < 40; i++) step("to40", 1, 0, 0, word_t'(i + 500));
    chk("to40.level", bus.level, 7'd40);
    step("clr40", 1, 0, 1, 32'hDEAD);
    chk("clr40.level", bus.level, 7'd0);
    chk("clr40.empty", bus.empty, 1'b1);
    chk("clr40.ovf", bus.overflow, 1'b0);
    step("clr40_rd", 0, 1, 0, '0);
    chk("clr40.not_stored", bus.data_valid, 1'b0);

    // Unconstrained random traffic, occasional clear, including full/empty saturation.
    for (int i = 0; i < 600; i++) begin
      we  = ($urandom_range(0, 3) != 0) ^ (i >= 300);
      ra  = ($urandom_range(0, 3) == 0) ^ (i >= 300);
      clr = ($urandom_range(0, 63) == 0);
      step("rand", we, ra, clr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
